// File: rtl/clkdiv_sched.sv
// Run/stop controller for a programmable divided clock: configurable half-period,
// optional burst length, clean stop at the end of a high phase, tick/done strobes.
module clkdiv_sched #(
  parameter int          CNT_W        = 32,
  parameter int          BURST_W      = 16,
  parameter int unsigned DEFAULT_HALF = 6250000
) (
  input  logic               iclk,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  output logic               oclk,
  output logic               tick,
  output logic               done,
  output logic               busy,
  output logic [1:0]         o_dbg_state
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STOPPING = 2'd2;

  localparam logic [CNT_W-1:0]   ONE_C    = CNT_W'(1);
  localparam logic [BURST_W-1:0] ONE_B    = BURST_W'(1);
  localparam logic [CNT_W-1:0]   DEF_HALF = (DEFAULT_HALF == 0) ? ONE_C : CNT_W'(DEFAULT_HALF);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_oclk;
  logic               r_tick;
  logic               r_done;
  logic [BURST_W-1:0] r_pcnt;
  logic [CNT_W-1:0]   r_half;
  logic [BURST_W-1:0] r_burst;

  logic               w_wrap;
  logic               w_fall;
  logic [BURST_W-1:0] w_pcnt_next;
  logic               w_complete;
  logic               w_run;

  assign w_wrap      = (r_count == (r_half - ONE_C));
  assign w_fall      = w_wrap && r_oclk;
  assign w_pcnt_next = r_pcnt + ONE_B;
  assign w_complete  = w_fall && (r_burst != '0) && (w_pcnt_next == r_burst);
  assign w_run       = (r_state == S_RUN);

  // Config handshake: a write is accepted on any edge where cfg_valid && cfg_ready;
  // cfg_ready is high only in IDLE, and writes while busy are dropped, not queued.
  assign cfg_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign oclk        = r_oclk;
  assign tick        = r_tick;
  assign done        = r_done;
  assign o_dbg_state = r_state;

  always_ff @(posedge iclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_oclk  <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_pcnt  <= '0;
      r_half  <= DEF_HALF;
      r_burst <= '0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_oclk <= 1'b0;
          if (cfg_valid) begin
            r_half  <= (cfg_half == '0) ? ONE_C : cfg_half;
            r_burst <= cfg_burst;
          end
          if (start) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_pcnt  <= '0;
          end
        end
        S_RUN, S_STOPPING: begin
          if (w_run && stop && !r_oclk) begin
            // Low phase: stop is immediate, and it suppresses a rising toggle due now.
            r_state <= S_IDLE;
            r_count <= '0;
          end else begin
            r_count <= w_wrap ? '0 : (r_count + ONE_C);
            if (w_wrap) begin
              r_oclk <= ~r_oclk;
              r_tick <= 1'b1;
            end
            if (w_fall) begin
              r_pcnt <= w_pcnt_next;
              if (w_complete) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else if (!w_run || stop) begin
                r_state <= S_IDLE;
              end
            end else if (w_run && stop) begin
              r_state <= S_STOPPING;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_oclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Testbench for clkdiv_sched: per-scenario tasks compare every cycle against an
// arithmetic model of elapsed-cycle behaviour after the start edge.
module tb_clkdiv_sched;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  logic               iclk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_valid = 1'b0;
  logic [CNT_W-1:0]   cfg_half = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic               cfg_ready;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               oclk;
  logic               tick;
  logic               done;
  logic               busy;
  logic [1:0]         dbg_state;

  int checks = 0;
  int failures = 0;

  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int         n_q[$];

  clkdiv_sched #(
    .CNT_W(CNT_W),
    .BURST_W(BURST_W),
    .DEFAULT_HALF(5)
  ) dut (
    .iclk(iclk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_half(cfg_half),
    .cfg_burst(cfg_burst),
    .cfg_ready(cfg_ready),
    .start(start),
    .stop(stop),
    .oclk(oclk),
    .tick(tick),
    .done(done),
    .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Expected {cfg_ready, busy, oclk, tick, done} n edges after the start edge,
  // for half h, burst b (0 = free-run) and stop sampled at edge s (0 = none).
  function automatic logic [4:0] model(input int n, input int h, input int b, input int s);
    int fin;
    int k;
    bit fin_tick;
    bit fin_done;
    fin      = (b != 0) ? 2 * b * h : -1;
    fin_tick = 1'b1;
    fin_done = (b != 0);
    if (s > 0 && (fin < 0 || s <= fin)) begin
      k = (s - 1) / h;
      if (k % 2 == 0) begin
        fin      = s;
        fin_tick = 1'b0;
        fin_done = 1'b0;
      end else begin
        fin      = (k + 1) * h;
        fin_tick = 1'b1;
        fin_done = (b != 0) && (fin == 2 * b * h);
      end
    end
    if (fin >= 0 && n >= fin)
      return {1'b1, 1'b0, 1'b0, (n == fin) && fin_tick, (n == fin) && fin_done};
    return {1'b0, 1'b1, ((n / h) % 2) == 1, (n > 0) && (n % h == 0), 1'b0};
  endfunction

  task automatic sample(input int n, input int h, input int b, input int s);
    exp_q.push_back(model(n, h, b, s));
    obs_q.push_back({cfg_ready, busy, oclk, tick, done});
    n_q.push_back(n);
  endtask

  // driver: optional config, start edge E0 (n=0), then ncyc further edges
  task automatic run_seq(input int h, input int cfg_h, input int b, input int s,
                         input int ncyc, input bit load, input bit same_cycle,
                         input bit start_stop, input bit noise);
    logic [4:0] prev;
    if (load && !same_cycle) begin
      cfg_valid = 1'b1;
      cfg_half  = cfg_h;
      cfg_burst = b;
      step();
    end
    cfg_valid = load && same_cycle;
    cfg_half  = cfg_h;
    cfg_burst = b;
    start     = 1'b1;
    stop      = start_stop;
    step();
    sample(0, h, b, s);
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      stop = (n == s);
      prev = model(n - 1, h, b, s);
      if (noise && prev[3]) begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_half  = $urandom_range(1, 20);
        cfg_burst = $urandom_range(0, 5);
        start     = 1'($urandom_range(0, 1));
      end else begin
        cfg_valid = 1'b0;
        start     = 1'b0;
      end
      step();
      sample(n, h, b, s);
    end
    stop      = 1'b0;
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    do_reset();
    o = {cfg_ready, busy, oclk, tick, done};
    checks++;
    if (o !== 5'b10000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", o, 5'b10000);
    end
  endtask

  task automatic test_burst();
    logic [4:0] e, o;
    int n, ticks;
    ticks = 0;
    do_reset();
    run_seq(3, 3, 2, 0, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = n_q.pop_front();
      ticks += int'(o[1]);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL burst n=%0d got=%b exp=%b", n, o, e);
      end
    end
    checks++;
    if (ticks != 4) begin
      failures++;
      $display("FAIL burst_tick_count got=%0d exp=4", ticks);
    end
  endtask

  task automatic test_default_freerun();
    logic [4:0] e, o;
    int n;
    do_reset();
    run_seq(5, 0, 0, 0, 45, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    run_seq(1, 0, 0, 0, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = n_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL default_freerun n=%0d got=%b exp=%b", n, o, e);
      end
    end
  endtask

  task automatic test_stop();
    logic [4:0] e, o;
    int n;
    do_reset();
    run_seq(4, 4, 0, 5, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    run_seq(4, 4, 0, 2, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    run_seq(4, 4, 0, 11, 14, 1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = n_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stop n=%0d got=%b exp=%b", n, o, e);
      end
    end
  endtask

  task automatic test_cfg_busy();
    logic [4:0] e, o;
    int n;
    do_reset();
    run_seq(3, 3, 1, 0, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    run_seq(3, 3, 1, 0, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    run_seq(2, 2, 2, 0, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = n_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL cfg_busy n=%0d got=%b exp=%b", n, o, e);
      end
    end
  endtask

  task automatic test_collisions();
    logic [4:0] e, o;
    int n;
    do_reset();
    run_seq(4, 4, 0, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    o = {cfg_ready, busy, oclk, tick, done};
    checks++;
    if (o !== 5'b10000) begin
      failures++;
      $display("FAIL reset_midrun got=%b exp=%b", o, 5'b10000);
    end
    run_seq(5, 0, 0, 0, 12, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    run_seq(2, 2, 1, 4, 7, 1'b1, 1'b1, 1'b0, 1'b0);
    run_seq(2, 2, 1, 0, 7, 1'b0, 1'b0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = n_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL collisions n=%0d got=%b exp=%b", n, o, e);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] e, o;
    int n, h, b, s, ncyc;
    for (int it = 0; it < 12; it++) begin
      h = $urandom_range(1, 5);
      b = $urandom_range(0, 3);
      s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * ((b == 0) ? 3 : b) * h + 2) : 0;
      if (b == 0 && s == 0) ncyc = 20;
      else if (b == 0) ncyc = s + h + 3;
      else ncyc = 2 * b * h + 3;
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      run_seq(h, h, b, s, ncyc, 1'b1, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
      if (b == 0 && s == 0) do_reset();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = n_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random n=%0d got=%b exp=%b", n, o, e);
      end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_burst();
    test_default_freerun();
    test_stop();
    test_cfg_busy();
    test_collisions();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
